// File: rtl/pc_unit_if.sv
// Fetch-control bundle between the PC stage and its drivers.
// Master drives stall/redirect/trap; slave (the PC stage) returns the fetch PC.
interface pc_unit_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vector;
  logic            is_compressed;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next_seq;
  logic [XLEN-1:0] pc_prev;
  logic            pc_valid;
  logic            misalign_err;
  logic [XLEN-1:0] misalign_addr;

  modport master (
    output stall, redirect_valid, redirect_target, trap_valid, trap_vector, is_compressed,
    input  pc, pc_next_seq, pc_prev, pc_valid, misalign_err, misalign_addr
  );

  modport slave (
    input  stall, redirect_valid, redirect_target, trap_valid, trap_vector, is_compressed,
    output pc, pc_next_seq, pc_prev, pc_valid, misalign_err, misalign_addr
  );
endinterface

// File: rtl/pc_unit.sv
// Registered fetch PC with priority trap > redirect > stall > sequential advance; one-cycle update latency.
// Optional 2-byte instruction support via `PC_COMPRESSED_EN (step 2 when is_compressed, 2-byte redirect alignment).
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              STEP         = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  pc_unit_if.slave bus
);

`ifdef PC_COMPRESSED_EN
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(1);
`else
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);
`endif

  logic [XLEN-1:0] pc_q,   pc_d;
  logic [XLEN-1:0] pc_prev_q, pc_prev_d;
  logic            pc_valid_q;
  logic            misalign_err_q, misalign_err_d;
  logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;

  logic [XLEN-1:0] step_w;
  logic [XLEN-1:0] pc_next_seq_w;
  logic            target_misaligned_w;

`ifdef PC_COMPRESSED_EN
  assign step_w = bus.is_compressed ? XLEN'(2) : XLEN'(STEP);
`else
  logic unused_is_compressed;
  assign unused_is_compressed = bus.is_compressed;
  assign step_w = XLEN'(STEP);
`endif

  // Truncating add: wrap past the top of the address space is silent.
  assign pc_next_seq_w       = pc_q + step_w;
  assign target_misaligned_w = |(bus.redirect_target & ALIGN_MASK);

  always_comb begin
    pc_d            = pc_q;
    misalign_err_d  = 1'b0;
    misalign_addr_d = misalign_addr_q;
    if (pc_valid_q) begin
      if (bus.trap_valid) begin
        pc_d = bus.trap_vector;
      end else if (bus.redirect_valid) begin
        if (target_misaligned_w) begin
          misalign_err_d  = 1'b1;
          misalign_addr_d = bus.redirect_target;
        end else begin
          pc_d = bus.redirect_target;
        end
      end else if (!bus.stall) begin
        pc_d = pc_next_seq_w;
      end
    end
  end

  // pc_prev tracks the last distinct PC so it stays a valid EPC across holds.
  assign pc_prev_d = (pc_d != pc_q) ? pc_q : pc_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q            <= RESET_VECTOR;
      pc_prev_q       <= RESET_VECTOR;
      pc_valid_q      <= 1'b0;
      misalign_err_q  <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      pc_q            <= pc_d;
      pc_prev_q       <= pc_prev_d;
      pc_valid_q      <= 1'b1;
      misalign_err_q  <= misalign_err_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.pc_next_seq   = pc_next_seq_w;
  assign bus.pc_prev       = pc_prev_q;
  assign bus.pc_valid      = pc_valid_q;
  assign bus.misalign_err  = misalign_err_q;
  assign bus.misalign_addr = misalign_addr_q;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter stage, the registered successor to the combinational PC+4 adder. Holds the architectural fetch PC and advances it by a fixed step each cycle. Supports stall, branch/jump redirect and trap redirect with fixed priority, plus alignment checking. Sits at the head of the fetch stage and drives the instruction-memory address.

Parameters:
XLEN, 32, PC width in bits (16..64).
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (XLEN bits, must be aligned).
STEP, 4, byte increment per sequential instruction (power of two, 2..8).

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
stall  in  1  hold PC this cycle (sequential advance only).
redirect_valid  in  1  branch/jump taken this cycle.
redirect_target  in  XLEN  branch/jump destination.
trap_valid  in  1  trap/exception redirect this cycle.
trap_vector  in  XLEN  trap handler address.
is_compressed  in  1  current instruction is 2 bytes (used only with PC_COMPRESSED_EN).
pc  out  XLEN  current fetch PC (registered).
pc_next_seq  out  XLEN  combinational pc + step, wraps modulo 2^XLEN.
pc_prev  out  XLEN  PC value before the most recent update (EPC source).
pc_valid  out  1  PC is valid for fetch.
misalign_err  out  1  one-cycle pulse: redirect target misaligned.
misalign_addr  out  XLEN  last misaligned target captured.

Behaviour:
- Reset (rst_n=0, asynchronous): pc=RESET_VECTOR, pc_prev=RESET_VECTOR, pc_valid=0, misalign_err=0, misalign_addr=0.
- pc_valid rises on the first clk edge after rst_n deasserts and stays 1 until the next reset.
- Step = STEP; with PC_COMPRESSED_EN and is_compressed=1, step = 2.
- pc_next_seq = pc + step, truncated to XLEN bits. 0xFFFFFFFC + 4 = 0x00000000, with no flag.
- Per-edge update priority, highest first:
  1. trap_valid: pc <= trap_vector. trap_vector is not alignment-checked.
  2. redirect_valid, target aligned: pc <= redirect_target.
  3. redirect_valid, target misaligned: pc holds; misalign_err=1 for exactly one cycle; misalign_addr <= redirect_target.
  4. stall: pc holds.
  5. Otherwise: pc <= pc_next_seq.
- Trap and redirect override stall.
- Simultaneous trap_valid and redirect_valid: trap wins; the redirect is dropped with no misalign check.
- Alignment: target[log2(STEP)-1:0] must be 0. With PC_COMPRESSED_EN, only target[0] must be 0.
- pc_prev <= pc on every edge where pc changes value; otherwise it holds.
- misalign_err is registered and returns to 0 on the following edge unless re-triggered.
- Inputs are ignored while pc_valid=0, i.e. the first edge after reset only sets pc_valid.
- Reset asserted mid-operation immediately forces all reset values, regardless of pending redirect/trap.
- Latency: redirect/trap visible on pc one cycle after being sampled.

Optional Feature:
PC_COMPRESSED_EN
- Defined: is_compressed selects a 2-byte step; redirect alignment relaxed to 2 bytes.
- Undefined: is_compressed is ignored (port kept, unused); step always STEP; alignment to STEP bytes.

Test Plan:
- Reset then free-run: rst_n low, release, 3 edges with no stall -> pc 0x0, 0x0 (pc_valid rises), 0x4, 0x8; pc_next_seq = pc+4.
- Wrap: redirect to 0xFFFFFFFC, next edge free-run -> pc 0xFFFFFFFC then 0x00000000; misalign_err=0.
- Stall vs redirect: stall=1 for 2 edges -> pc held at 0x8; stall=1 with redirect_valid=1, target 0x100 -> pc=0x100, pc_prev=0x8.
- Priority: trap_valid=1 (vector 0x80) with redirect_valid=1 (0x200) -> pc=0x80, misalign_err=0.
- Misaligned redirect: target 0x102 (no macro) -> pc held, misalign_err=1 for one cycle, misalign_addr=0x102. With PC_COMPRESSED_EN -> pc=0x102, no error.
- Async reset mid-run: pc=0x40, assert rst_n between edges -> pc=RESET_VECTOR and pc_valid=0 immediately, without waiting for a clock edge.
